fsc_004_rx: RTL and testbench

Single-clock serial frame receiver for the 1-bit line produced by the FSC delay/shift chains. It detects a start bit on the idle-low line and shifts in DATA_W data bits LSB first. It then checks even parity and the stop bit, and presents the recovered word on a valid/ready output. It is the consuming end of the serial bitstream: the parallel-word reader for a one-bit-per-clock serial writer.

---
 rtl/fsc_004_rx.sv | 138 +++++++++++++
 tb/tb_fsc_004_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fsc_004_rx.sv
// fsc_004_rx: one-bit-per-clock serial frame receiver.
// Frame: start(1), DATA_W data bits LSB first, even parity, stop(0).
// Good frames go out on a valid/ready port. Bad frames and dropped frames pulse flags.
module fsc_004_rx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ia,
  input  logic              iready,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic              operr,
  output logic              oovr,
  output logic              obusy
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic              operr_q, operr_d;
  logic              oovr_q, oovr_d;
  logic              obusy_q, obusy_d;

  logic [DATA_W-1:0] shift_c;
  logic              frame_good_c;

  // The line shifts in at the MSB. After DATA_W shifts the first bit sits at bit 0.
  if (DATA_W == 1) begin : g_shift_w1
    assign shift_c = ia;
  end else begin : g_shift_wn
    assign shift_c = {ia, shreg_q[DATA_W-1:1]};
  end

  // Evaluated in STOP: the stop bit must be low and the parity must be even.
  assign frame_good_c = ~ia & (par_q == (^shreg_q));

  // State and output registers
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      operr_q  <= 1'b0;
      oovr_q   <= 1'b0;
      obusy_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      operr_q  <= operr_d;
      oovr_q   <= oovr_d;
      obusy_q  <= obusy_d;
    end
  end

  // Next-state: frame sequencing, frame evaluation and the output handshake
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    operr_d  = 1'b0;
    oovr_d   = 1'b0;

    // A transfer on this edge releases the held word.
    if (ovalid_q && iready) begin
      ovalid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ia) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        shreg_d = shift_c;
        if (cnt_q == LAST_BIT) begin
          state_d = S_PARITY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        par_d   = ia;
        state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!frame_good_c) begin
          operr_d = 1'b1;
        end else if (!ovalid_q || iready) begin
          // The slot is empty, or the old word leaves on this edge.
          odata_d  = shreg_q;
          ovalid_d = 1'b1;
        end else begin
          oovr_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    obusy_d = (state_d != S_IDLE);
  end

  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign operr  = operr_q;
  assign oovr   = oovr_q;
  assign obusy  = obusy_q;

endmodule

// File: tb/tb_fsc_004_rx.sv
// Testbench for fsc_004_rx. A frame-level queue model predicts the outputs.
// The bench uses a table of directed frames, hand-written corner sequences and random frames.
module tb_fsc_004_rx;

  localparam int unsigned W = 8;

  logic         iclk;
  logic         irst;
  logic         ia;
  logic         iready;
  logic [W-1:0] odata;
  logic         ovalid;
  logic         operr;
  logic         oovr;
  logic         obusy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           m_busy;
  bit           m_valid;
  bit           m_err;
  bit           m_ovr;
  logic [W-1:0] m_data;
  logic         mq[$];

  typedef struct {
    logic [W-1:0] d;
    bit           pbad;
    bit           stopv;
    bit           rdy;
    logic [W-1:0] e_data;
    bit           e_valid;
    bit           e_err;
    bit           e_ovr;
  } vec_t;

  vec_t tbl[8];

  fsc_004_rx #(.DATA_W(W)) dut (
    .iclk   (iclk),
    .irst   (irst),
    .ia     (ia),
    .iready (iready),
    .odata  (odata),
    .ovalid (ovalid),
    .operr  (operr),
    .oovr   (oovr),
    .obusy  (obusy)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk1({tag, ".odata"},  32'(odata),  32'(m_data));
    chk1({tag, ".ovalid"}, 32'(ovalid), 32'(m_valid));
    chk1({tag, ".operr"},  32'(operr),  32'(m_err));
    chk1({tag, ".oovr"},   32'(oovr),   32'(m_ovr));
    chk1({tag, ".obusy"},  32'(obusy),  32'(m_busy));
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
    m_data  = '0;
    mq.delete();
  endtask

  // Collect the bits after a start. Judge the frame once W+2 bits have arrived.
  task automatic model_step(input logic a, input logic r);
    logic [W-1:0] d;
    logic         p;
    logic         s;
    bit           v0;
    v0    = m_valid;
    m_err = 1'b0;
    m_ovr = 1'b0;
    if (v0 && r) m_valid = 1'b0;
    if (!m_busy) begin
      if (a) begin
        m_busy = 1'b1;
        mq.delete();
      end
    end else begin
      mq.push_back(a);
      if (mq.size() == int'(W) + 2) begin
        for (int i = 0; i < int'(W); i++) d[i] = mq[i];
        p      = mq[W];
        s      = mq[W+1];
        m_busy = 1'b0;
        if (s || (p != ^d)) m_err = 1'b1;
        else if (!v0 || r) begin
          m_data  = d;
          m_valid = 1'b1;
        end else m_ovr = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic a, input logic r, input string tag);
    ia     = a;
    iready = r;
    @(posedge iclk);
    if (irst) model_reset();
    else model_step(a, r);
    #1;
    chk_all(tag);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit pbad, input logic stopv,
                            input logic rs, input logic ro);
    tick(1'b1, ro, "start");
    for (int i = 0; i < int'(W); i++) tick(d[i], ro, "data");
    tick((^d) ^ pbad, ro, "par");
    tick(stopv, rs, "stop");
  endtask

  initial begin
    logic fb[11];
    int   first;
    logic [W-1:0] rd;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};

    irst   = 1'b1;
    ia     = 1'b0;
    iready = 1'b0;
    model_reset();
    repeat (2) @(posedge iclk);
    #1;
    chk_all("reset");
    irst = 1'b0;

    // A long idle line with random ready must leave every output low.
    repeat (50) tick(1'b0, 1'($urandom_range(0, 1)), "idle");

    // 0xA5 frame: ovalid rises on the 10th edge after the start edge.
    rd = 8'hA5;
    fb[0] = 1'b1;
    for (int i = 0; i < 8; i++) fb[i+1] = rd[i];
    fb[9]  = ^rd;
    fb[10] = 1'b0;
    first  = -1;
    for (int i = 0; i < 11; i++) begin
      tick(fb[i], 1'b0, "lat");
      if (ovalid && first < 0) first = i;
    end
    chk1("lat_cycles", 32'(first), 32'd10);
    chk1("lat_data", 32'(odata), 32'hA5);
    tick(1'b0, 1'b1, "accept");
    chk1("accept_clears", 32'(ovalid), 32'd0);

    // Back-to-back directed frames, checked against the table
    for (int k = 0; k < 8; k++) begin
      send_frame(tbl[k].d, tbl[k].pbad, tbl[k].stopv, tbl[k].rdy, 1'b0);
      chk1($sformatf("tbl%0d.odata", k),  32'(odata),  32'(tbl[k].e_data));
      chk1($sformatf("tbl%0d.ovalid", k), 32'(ovalid), 32'(tbl[k].e_valid));
      chk1($sformatf("tbl%0d.operr", k),  32'(operr),  32'(tbl[k].e_err));
      chk1($sformatf("tbl%0d.oovr", k),   32'(oovr),   32'(tbl[k].e_ovr));
    end
    tick(1'b0, 1'b0, "post_tbl");
    chk1("err_pulse_1cyc", 32'(operr | oovr), 32'd0);

    // Reset in the middle of a frame while a word is still held
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, "mid_start");
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, "mid_data");
    irst = 1'b1;
    model_reset();
    #1;
    chk_all("rst_async");
    chk1("rst_async_valid", 32'(ovalid), 32'd0);
    tick(1'b1, 1'b0, "rst_hold");
    tick(1'b0, 1'b0, "rst_hold");
    irst = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("after_rst.odata", 32'(odata), 32'h5A);
    chk1("after_rst.operr", 32'(operr), 32'd0);

    // A stop error followed by an idle line: the receiver stays idle
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    chk1("stop_err", 32'(operr), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, "stop_idle");
      chk1("stop_idle_busy", 32'(obusy), 32'd0);
    end

    // Random frames, gaps and ready
    for (int f = 0; f < 300; f++) begin
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom_range(0, 1)), "gap");
      send_frame(W'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) tick(1'b0, 1'b1, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
